pmem_line_responder: RTL



---
 rtl/pmem_line_responder_pkg.sv | 26 ++
 rtl/pmem_line_responder_line_array.sv | 44 ++++
 rtl/pmem_line_responder.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/pmem_line_responder_pkg.sv
// Shared types for the physical-memory line responder.
// Holds the LC-3b word/line types, the line index type and the responder
// FSM state encoding, which is exposed on the debug state output.
package pmem_line_responder_pkg;

  typedef logic [15:0]  lc3b_word;
  typedef logic [127:0] lc3b_line;

  // Default array geometry: 32 lines of 128 bits.
  localparam int PMEM_DEPTH_LOG2_DEFAULT = 5;
  typedef logic [PMEM_DEPTH_LOG2_DEFAULT-1:0] lc3b_pmem_index;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BUSY    = 2'd1,
    RESPOND = 2'd2,
    DONE    = 2'd3
  } pmem_state_t;

  // Plain 2-bit constants so the FSM register stays a simple vector.
  localparam logic [1:0] ST_IDLE    = IDLE;
  localparam logic [1:0] ST_BUSY    = BUSY;
  localparam logic [1:0] ST_RESPOND = RESPOND;
  localparam logic [1:0] ST_DONE    = DONE;

endpackage

// File: rtl/pmem_line_responder_line_array.sv
// Line storage for the responder: 2^DEPTH_LOG2 x 128-bit lines with a
// synchronous write port, a registered read port and a synchronous clear
// that wipes every line and the read register.
module pmem_line_array
  import pmem_line_responder_pkg::*;
#(
  parameter int DEPTH_LOG2 = 5
) (
  input  logic                  clk_i,
  input  logic                  clr_i,
  input  logic                  we_i,
  input  logic [DEPTH_LOG2-1:0] waddr_i,
  input  lc3b_line              wdata_i,
  input  logic                  re_i,
  input  logic [DEPTH_LOG2-1:0] raddr_i,
  output lc3b_line              rdata_o
);

  localparam int DEPTH = 1 << DEPTH_LOG2;

  lc3b_line mem_q [DEPTH];
  lc3b_line rdata_q;

  // Storage update: clear everything, or write one line and/or capture a read.
  always_ff @(posedge clk_i) begin
    if (clr_i) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      rdata_q <= '0;
    end else begin
      if (we_i) begin
        mem_q[waddr_i] <= wdata_i;
      end
      // The read register holds its value until the next read.
      if (re_i) begin
        rdata_q <= mem_q[raddr_i];
      end
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/pmem_line_responder.sv
// Memory-side responder for the cache's 128-bit pmem line interface.
// Accepts one line read or write, waits LATENCY cycles, then pulses
// pmem_resp for one cycle. A DONE cycle follows every response so a request
// the initiator is still dropping is never accepted twice.
//
// Handshake: pmem_read/pmem_write act as valid and are held until the
// pmem_resp cycle; pmem_resp acts as a one-cycle ready/completion. Request
// inputs are sampled only in IDLE and ignored in BUSY, RESPOND and DONE.
//
// Optional build macro PMEM_PROTO_CHECK_EN adds a sticky proto_err output
// that flags read+write together and requests dropped or re-addressed in BUSY.
module pmem_line_responder
  import pmem_line_responder_pkg::*;
#(
  parameter int LATENCY    = 10,
  parameter int DEPTH_LOG2 = 5
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       pmem_read,
  input  logic       pmem_write,
  input  lc3b_word   pmem_address,
  input  lc3b_line   pmem_wdata,
  output lc3b_line   pmem_rdata,
  output logic       pmem_resp,
`ifdef PMEM_PROTO_CHECK_EN
  output logic       proto_err,
`endif
  output logic [1:0] state_o
);

  localparam logic [7:0] CNT_LOAD = 8'(LATENCY - 1);

  logic [1:0]            state_q, state_d;
  logic [7:0]            cnt_q, cnt_d;
  logic                  write_q, write_d;
  logic [DEPTH_LOG2-1:0] idx_q, idx_d;
  lc3b_line              wdata_q, wdata_d;

  logic                  req;
  logic [DEPTH_LOG2-1:0] req_idx;
  logic                  rd_en;
  logic [DEPTH_LOG2-1:0] rd_idx;
  logic                  wr_en;

  assign req     = pmem_read | pmem_write;
  assign req_idx = pmem_address[DEPTH_LOG2+3:4];

  // Byte-offset and aliasing address bits carry no meaning here.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{pmem_address[15:DEPTH_LOG2+4], pmem_address[3:0]};

  // Next-state logic: accept in IDLE, count down in BUSY, one RESPOND and one DONE cycle.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    write_d = write_q;
    idx_d   = idx_q;
    wdata_d = wdata_q;
    rd_en   = 1'b0;
    rd_idx  = idx_q;
    case (state_q)
      ST_IDLE: begin
        if (req) begin
          // Write wins when both request lines are high.
          write_d = pmem_write;
          idx_d   = req_idx;
          wdata_d = pmem_wdata;
          if (LATENCY == 1) begin
            state_d = ST_RESPOND;
            cnt_d   = '0;
            rd_en   = ~pmem_write;
            rd_idx  = req_idx;
          end else begin
            state_d = ST_BUSY;
            cnt_d   = CNT_LOAD;
          end
        end
      end
      ST_BUSY: begin
        if (cnt_q <= 8'd1) begin
          // Counter reaches zero: capture read data on entry to RESPOND.
          state_d = ST_RESPOND;
          cnt_d   = '0;
          rd_en   = ~write_q;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      ST_RESPOND: state_d = ST_DONE;
      ST_DONE:    state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  // FSM, counter and latched request registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      write_q <= 1'b0;
      idx_q   <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      write_q <= write_d;
      idx_q   <= idx_d;
      wdata_q <= wdata_d;
    end
  end

  // Writes commit at the end of the RESPOND cycle, before DONE lets anything new in.
  assign wr_en = (state_q == ST_RESPOND) && write_q;

  pmem_line_array #(
    .DEPTH_LOG2(DEPTH_LOG2)
  ) u_array (
    .clk_i   (clk),
    .clr_i   (reset),
    .we_i    (wr_en),
    .waddr_i (idx_q),
    .wdata_i (wdata_q),
    .re_i    (rd_en),
    .raddr_i (rd_idx),
    .rdata_o (pmem_rdata)
  );

  assign pmem_resp = (state_q == ST_RESPOND);
  assign state_o   = state_q;

`ifdef PMEM_PROTO_CHECK_EN
  logic     err_q, err_d;
  lc3b_word addr_q;
  logic     busy_drop;
  logic     busy_move;

  assign busy_drop = (state_q == ST_BUSY) && (write_q ? ~pmem_write : ~pmem_read);
  assign busy_move = (state_q == ST_BUSY) && (pmem_address != addr_q);

  // Sticky protocol error flag; only reset clears it.
  always_comb begin
    err_d = err_q | (pmem_read & pmem_write) | busy_drop | busy_move;
  end

  // Protocol checker state: full request address plus the sticky flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      err_q  <= 1'b0;
      addr_q <= '0;
    end else begin
      err_q <= err_d;
      if ((state_q == ST_IDLE) && req) begin
        addr_q <= pmem_address;
      end
    end
  end

  assign proto_err = err_q;
`endif

endmodule
